// File: rtl/mmss_display_pkg.sv
// rtl/mmss_display_pkg.sv - shared types, segment/anode patterns and BCD helpers for the MM:SS display driver
package mmss_display_pkg;

    typedef logic [1:0] digit_idx_t;
    typedef logic [3:0] bcd_t;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low anode patterns; D0 is the rightmost digit (seconds ones)
    localparam logic [3:0] AN_OFF = 4'b1111;
    localparam logic [3:0] AN_D0  = 4'b1110;
    localparam logic [3:0] AN_D1  = 4'b1101;
    localparam logic [3:0] AN_D2  = 4'b1011;
    localparam logic [3:0] AN_D3  = 4'b0111;

    // Tens digit of a 6-bit binary value; 60..63 yield 6 (no saturation)
    function automatic bcd_t bcd_tens(input logic [5:0] value);
        return bcd_t'(value / 6'd10);
    endfunction

    // Ones digit of a 6-bit binary value
    function automatic bcd_t bcd_ones(input logic [5:0] value);
        return bcd_t'(value % 6'd10);
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational BCD to active-low 7-segment decoder
module seg7_decoder
    import mmss_display_pkg::*;
(
    input  bcd_t       bcd_i,
    output logic [6:0] seg_o
);

    // Codes 10..15 never come from a valid BCD split, so they show dark
    always_comb begin
        seg_o = SEG_BLANK;
        case (bcd_i)
            4'd0:    seg_o = SEG_0;
            4'd1:    seg_o = SEG_1;
            4'd2:    seg_o = SEG_2;
            4'd3:    seg_o = SEG_3;
            4'd4:    seg_o = SEG_4;
            4'd5:    seg_o = SEG_5;
            4'd6:    seg_o = SEG_6;
            4'd7:    seg_o = SEG_7;
            4'd8:    seg_o = SEG_8;
            4'd9:    seg_o = SEG_9;
            default: seg_o = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/mmss_display_driver.sv
// rtl/mmss_display_driver.sv - 4-digit multiplexed MM:SS display driver (optional LEADING_ZERO_BLANK_EN)
module mmss_display_driver
    import mmss_display_pkg::*;
#(
    parameter int DIGIT_DIV = 100_000
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] minutes,
    input  logic [5:0] seconds,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int              PW         = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(DIGIT_DIV - 1);

    logic [PW-1:0] presc_q, presc_d;
    digit_idx_t    idx_q, idx_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;

    logic          running;
    logic          tick;
    bcd_t          digit_sel;
    logic [6:0]    dec_seg;

    // The dark state only exists after reset. The first edge out of it lights
    // digit 0 and holds the prescaler at 0, so that digit gets a full
    // DIGIT_DIV-cycle slot like every later one.
    assign running = (an_q != AN_OFF);
    assign tick    = running && (presc_q == PRESC_LAST);

    // Prescaler and digit index next state
    always_comb begin
        presc_d = presc_q + PW'(1);
        idx_d   = idx_q;
        if (!running || tick) begin
            presc_d = '0;
        end
        if (tick) begin
            idx_d = idx_q + 2'd1;
        end
    end

    // Select anode and digit for the index that will be active after this edge,
    // so an and seg always switch together
    always_comb begin
        an_d      = AN_D0;
        digit_sel = bcd_ones(seconds);
        case (idx_d)
            2'd0: begin an_d = AN_D0; digit_sel = bcd_ones(seconds); end
            2'd1: begin an_d = AN_D1; digit_sel = bcd_tens(seconds); end
            2'd2: begin an_d = AN_D2; digit_sel = bcd_ones(minutes); end
            2'd3: begin an_d = AN_D3; digit_sel = bcd_tens(minutes); end
            default: begin an_d = AN_D0; digit_sel = bcd_ones(seconds); end
        endcase
    end

    seg7_decoder u_seg7_decoder (
        .bcd_i (digit_sel),
        .seg_o (dec_seg)
    );

    // Segment next state, with optional blanking of a leading zero minute
    always_comb begin
        seg_d = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx_d == 2'd3 && bcd_tens(minutes) == 4'd0) begin
            seg_d = SEG_BLANK;
        end
`endif
    end

    // State registers with synchronous active-high reset to a dark display
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= 2'd0;
            an_q    <= AN_OFF;
            seg_q   <= SEG_BLANK;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_mmss_display_driver.sv
// tb/tb_mmss_display_driver.sv - self-checking bench for mmss_display_driver
module tb_mmss_display_driver;

    localparam int DD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] minutes = 6'd0;
    logic [5:0] seconds = 6'd0;
    logic [6:0] seg;
    logic [3:0] an;

    int checks   = 0;
    int failures = 0;
    int k        = 0;   // clk edges since reset released (0 while in reset)

    logic [6:0] seg_tbl [10];

    mmss_display_driver #(.DIGIT_DIV(DD)) dut (
        .clk     (clk),
        .rst     (rst),
        .minutes (minutes),
        .seconds (seconds),
        .seg     (seg),
        .an      (an)
    );

    always #5 clk = ~clk;

    // Watchdog so the bench always ends
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int cur_idx();
        return ((k - 1) / DD) % 4;
    endfunction

    task automatic check(input string tag, input logic [10:0] got, input logic [10:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got an=%b seg=%b expected an=%b seg=%b", tag,
                   got[10:7], got[6:0], exp[10:7], exp[6:0]);
        end
    endtask

    // Advance one clock and compare against the reference model
    task automatic step(input string tag);
        int         idx;
        int         val;
        int         code;
        logic [3:0] exp_an;
        logic [6:0] exp_seg;
        @(posedge clk);
        if (rst) k = 0; else k++;
        #1;
        if (k == 0) begin
            exp_an  = 4'b1111;
            exp_seg = 7'b1111111;
        end else begin
            idx    = cur_idx();
            exp_an = 4'b1111;
            exp_an[idx] = 1'b0;
            val  = (idx < 2) ? int'(seconds) : int'(minutes);
            code = (idx % 2 == 0) ? (val % 10) : (val / 10);
            exp_seg = (code <= 9) ? seg_tbl[code] : 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
            if (idx == 3 && code == 0) exp_seg = 7'b1111111;
`endif
        end
        check(tag, {an, seg}, {exp_an, exp_seg});
    endtask

    initial begin
        seg_tbl[0] = 7'b1000000; seg_tbl[1] = 7'b1111001;
        seg_tbl[2] = 7'b0100100; seg_tbl[3] = 7'b0110000;
        seg_tbl[4] = 7'b0011001; seg_tbl[5] = 7'b0010010;
        seg_tbl[6] = 7'b0000010; seg_tbl[7] = 7'b1111000;
        seg_tbl[8] = 7'b0000000; seg_tbl[9] = 7'b0010000;

        // Reset held for three cycles: dark display
        rst = 1'b1; minutes = 6'd12; seconds = 6'd34;
        for (int i = 0; i < 3; i++) step("reset_dark");
        check("reset_dark_literal", {an, seg}, {4'b1111, 7'b1111111});

        // Release and scan 12:34 through five digit slots
        rst = 1'b0;
        step("first_edge");
        check("first_edge_literal", {an, seg}, {4'b1110, 7'b0011001});
        for (int i = 0; i < 5 * DD - 1; i++) step("scan_1234");
        check("scan_wrap_literal", {an, seg}, {4'b1110, 7'b0011001});

        // Input change mid-digit while digit 0 is lit
        rst = 1'b1; step("pre_change_reset");
        rst = 1'b0; step("pre_change_lit");
        seconds = 6'd35;
        step("mid_digit_change");
        check("mid_digit_change_literal", {an, seg}, {4'b1110, 7'b0010010});

        // Reset in the middle of the scan while digit 2 is lit
        while (!(k >= 1 && cur_idx() == 2)) step("run_to_idx2");
        step("idx2_hold");
        rst = 1'b1; step("midscan_reset");
        check("midscan_reset_literal", {an, seg}, {4'b1111, 7'b1111111});
        rst = 1'b0;
        for (int i = 0; i < 2 * DD + 1; i++) step("restart_scan");

        // Digit sweep, each value held for a full scan
        for (int s = 0; s < 60; s++) begin
            seconds = 6'(s);
            minutes = 6'((s * 7) % 60);
            for (int i = 0; i < 4 * DD; i++) step("sweep");
        end
        seconds = 6'd59; minutes = 6'd59;
        for (int i = 0; i < 4 * DD; i++) step("sweep_5959");
        seconds = 6'd0; minutes = 6'd0;
        for (int i = 0; i < 4 * DD; i++) step("sweep_0000");
        seconds = 6'd15; minutes = 6'd5;
        for (int i = 0; i < 4 * DD; i++) step("minutes_05");
        minutes = 6'd15;
        for (int i = 0; i < 4 * DD; i++) step("minutes_15");
        seconds = 6'd63; minutes = 6'd60;
        for (int i = 0; i < 4 * DD; i++) step("out_of_range");

        // Randomized inputs, including 60..63 and occasional reset pulses
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) seconds = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 7) == 0) minutes = 6'($urandom_range(0, 63));
            rst = ($urandom_range(0, 49) == 0);
            step("random");
        end
        rst = 1'b0;
        for (int i = 0; i < 4 * DD; i++) step("random_tail");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
